// File: rtl/seg_pkg.sv
// Shared types for the seven-segment display front end and animation block.
package seg_pkg;

  // Rotation mode selected by the most recent accepted press.
  typedef enum logic [1:0] {
    ROT_L = 2'b00,
    ROT_R = 2'b01,
    ROT_C = 2'b10
  } rot_t;

  localparam rot_t ROT_RESET = ROT_C;

  // Priority encode coincident presses {c, r, l}: centre beats right beats left.
  function automatic rot_t rot_select(input logic [2:0] rises);
    rot_t w_sel;
    if (rises[2]) begin
      w_sel = ROT_C;
    end else if (rises[1]) begin
      w_sel = ROT_R;
    end else begin
      w_sel = ROT_L;
    end
    return w_sel;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, counter debouncer, rising-edge detect.
// 'level' is the registered debounced state; 'rise' is high for the single
// cycle after 'level' flips 0->1 and is meant to be registered by the parent.
module debounce_channel #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples;
  // reaching terminal count forces the clear, so the counter never wraps.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= r_level;
    end
  end

  assign level = r_level;
  assign rise  = r_level & ~r_level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the left/right/centre buttons into press pulses, a restart
// pulse and a registered rotation mode for the display animation block.
module button_conditioner
  import seg_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  output logic       press_l,
  output logic       press_r,
  output logic       press_c,
  output logic [2:0] held,
  output logic [1:0] rotation,
  output logic       restart
);

  logic [2:0] w_level;
  logic [2:0] w_rise;
  logic [2:0] r_press;
  logic       r_restart;
  rot_t       r_rotation;

  debounce_channel #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_l (
    .clk(clk), .clr_n(clr_n), .raw(btn_l), .level(w_level[0]), .rise(w_rise[0])
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_r (
    .clk(clk), .clr_n(clr_n), .raw(btn_r), .level(w_level[1]), .rise(w_rise[1])
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch_c (
    .clk(clk), .clr_n(clr_n), .raw(btn_c), .level(w_level[2]), .rise(w_rise[2])
  );

  // Register press pulses, restart and rotation together so they coincide.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_press    <= 3'b000;
      r_restart  <= 1'b0;
      r_rotation <= ROT_RESET;
    end else begin
      r_press   <= w_rise;
      r_restart <= |w_rise;
      if (|w_rise) begin
        r_rotation <= rot_select(w_rise);
      end
    end
  end

  assign press_l  = r_press[0];
  assign press_r  = r_press[1];
  assign press_c  = r_press[2];
  assign restart  = r_restart;
  assign held     = w_level;
  assign rotation = r_rotation;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DB_CYCLES=4.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int W  = 37;  // {cycle[31:0], press{c,r,l}[2:0], rotation[1:0]}

  logic       clk;
  logic       clr_n;
  logic       btn_l, btn_r, btn_c;
  logic       press_l, press_r, press_c;
  logic [2:0] held;
  logic [1:0] rotation;
  logic       restart;

  int checks = 0;
  int errors = 0;

  button_conditioner #(.DB_CYCLES(DB)) dut (
    .clk(clk), .clr_n(clr_n), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
    .press_l(press_l), .press_r(press_r), .press_c(press_c),
    .held(held), .rotation(rotation), .restart(restart)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A button level is accepted once the synchronised input (raw value two
  // samples back) has disagreed with the accepted level for DB samples in a
  // row; an accepted 0->1 appears as a press one edge later.
  logic [W-1:0] exp_q[$];
  logic [2:0]   hist_q[$];
  logic [2:0]   m_d;
  int           m_run[3];
  logic [2:0]   m_pend;
  logic [1:0]   m_rot;

  always @(posedge clk or negedge clr_n) begin : model_blk
    logic sb;
    if (!clr_n) begin
      m_d    = 3'b000;
      m_pend = 3'b000;
      m_rot  = 2'b10;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      hist_q.delete();
      exp_q.delete();
    end else begin
      if (|m_pend) begin
        if (m_pend[2])      m_rot = 2'b10;
        else if (m_pend[1]) m_rot = 2'b01;
        else                m_rot = 2'b00;
        exp_q.push_back({cyc + 1, m_pend, m_rot});
      end
      m_pend = 3'b000;
      for (int ch = 0; ch < 3; ch++) begin
        sb = (hist_q.size() >= 2) ? hist_q[hist_q.size()-2][ch] : 1'b0;
        if (sb != m_d[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DB) begin
            m_d[ch]   = sb;
            m_run[ch] = 0;
            if (sb) m_pend[ch] = 1'b1;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      hist_q.push_back({btn_c, btn_r, btn_l});
      if (hist_q.size() > 3) void'(hist_q.pop_front());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int press_cnt[3];
  int last_press_cyc[3];
  int restart_cnt = 0;

  always @(negedge clk) begin : mon_blk
    logic [W-1:0] e;
    logic [2:0]   p;
    if (clr_n) begin
      p = {press_c, press_r, press_l};
      chk("restart_is_or", {63'd0, restart}, {63'd0, |p});
      chk("held", {61'd0, held}, {61'd0, m_d});
      chk("rotation", {62'd0, rotation}, {62'd0, m_rot});
      if (restart) restart_cnt++;
      for (int ch = 0; ch < 3; ch++) begin
        if (p[ch]) begin
          press_cnt[ch]++;
          last_press_cyc[ch] = cyc;
        end
      end
      if (|p) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_press", {61'd0, p}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("press_cycle", 64'(cyc), 64'(e[36:5]));
          chk("press_bits", {61'd0, p}, {61'd0, e[4:2]});
          chk("press_rotation", {62'd0, rotation}, {62'd0, e[1:0]});
        end
      end
      while (exp_q.size() > 0 && int'(exp_q[0][36:5]) < cyc) begin
        e = exp_q.pop_front();
        chk("missed_press_cycle", 64'(cyc), 64'(e[36:5]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Set buttons at a falling edge and keep them for n cycles.
  task automatic hold(input logic l, input logic r, input logic c, input int n);
    @(negedge clk);
    btn_l = l; btn_r = r; btn_c = c;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 clr_n = 1'b0;
    @(posedge clk);
    #3 clr_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_press"}, {61'd0, press_c, press_r, press_l}, 64'd0);
    chk({tag, "_restart"}, {63'd0, restart}, 64'd0);
    chk({tag, "_held"}, {61'd0, held}, 64'd0);
    chk({tag, "_rotation"}, {62'd0, rotation}, 64'd2);
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int pc0[3];
  int rc0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      press_cnt[i] = 0;
      last_press_cyc[i] = -1;
    end
    clr_n = 1'b0;
    btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init_reset");
    @(posedge clk);
    #3 clr_n = 1'b1;
    hold(0, 0, 0, 5);

    // Clean press on left
    pc0 = press_cnt;
    hold(1, 0, 0, 1);
    t0 = cyc;
    repeat (19) @(negedge clk);
    chk("clean_latency", 64'(last_press_cyc[0]), 64'(t0 + 7));
    chk("clean_rotation", {62'd0, rotation}, 64'd0);
    hold(0, 0, 0, 15);
    chk("clean_count", 64'(press_cnt[0] - pc0[0]), 64'd1);

    // Bounce on right: high 1, low 2, high 1, low 3, then hold
    pc0 = press_cnt;
    hold(0, 1, 0, 1);
    hold(0, 0, 0, 2);
    hold(0, 1, 0, 1);
    hold(0, 0, 0, 3);
    chk("bounce_no_pulse", 64'(press_cnt[1] - pc0[1]), 64'd0);
    hold(0, 1, 0, 1);
    t0 = cyc;
    repeat (19) @(negedge clk);
    chk("bounce_latency", 64'(last_press_cyc[1]), 64'(t0 + 7));
    chk("bounce_count", 64'(press_cnt[1] - pc0[1]), 64'd1);
    chk("bounce_rotation", {62'd0, rotation}, 64'd1);
    hold(0, 0, 0, 12);

    // Simultaneous L+R+C, then a mid-cycle reset while all are held
    pc0 = press_cnt;
    rc0 = restart_cnt;
    hold(1, 1, 1, 15);
    chk("sim3_same_cycle_lr", 64'(last_press_cyc[0]), 64'(last_press_cyc[1]));
    chk("sim3_same_cycle_rc", 64'(last_press_cyc[1]), 64'(last_press_cyc[2]));
    chk("sim3_restart_count", 64'(restart_cnt - rc0), 64'd1);
    chk("sim3_rotation", {62'd0, rotation}, 64'd2);
    chk("sim3_held", {61'd0, held}, 64'd7);
    @(posedge clk);
    #3 clr_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    #3 clr_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("sim3_counts_after_reset", 64'(press_cnt[0] - pc0[0]), 64'd2);
    hold(0, 0, 0, 12);

    // Simultaneous L+R only
    pc0 = press_cnt;
    rc0 = restart_cnt;
    hold(1, 1, 0, 15);
    chk("sim2_same_cycle", 64'(last_press_cyc[0]), 64'(last_press_cyc[1]));
    chk("sim2_restart_count", 64'(restart_cnt - rc0), 64'd1);
    chk("sim2_rotation", {62'd0, rotation}, 64'd1);
    hold(0, 0, 0, 12);

    // Reset mid-debounce on centre
    pc0 = press_cnt;
    hold(0, 0, 1, 3);
    @(posedge clk);
    #3 clr_n = 1'b0;
    @(posedge clk);
    #3 clr_n = 1'b1;
    t0 = cyc;
    chk("middb_no_early_pulse", 64'(press_cnt[2] - pc0[2]), 64'd0);
    repeat (12) @(negedge clk);
    chk("middb_latency", 64'(last_press_cyc[2]), 64'(t0 + 7));
    chk("middb_count", 64'(press_cnt[2] - pc0[2]), 64'd1);
    chk("middb_rotation", {62'd0, rotation}, 64'd2);
    hold(0, 0, 0, 12);

    // Long hold on right
    pc0 = press_cnt;
    hold(0, 1, 0, 1);
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      if (i >= 6) chk("long_held_r", {63'd0, held[1]}, 64'd1);
    end
    chk("long_count", 64'(press_cnt[1] - pc0[1]), 64'd1);
    hold(0, 0, 0, 12);

    // Randomised bouncing on all channels with occasional resets
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 40) == 0) begin
        reset_pulse();
      end else begin
        hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
      end
    end
    hold(0, 0, 0, 20);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the dancing seven-segment display: it turns the three raw, bouncing push-buttons (left, right, centre) into clean single-cycle press pulses and a registered rotation-mode value. The display/animation block downstream uses `rotation` to select its pattern table and `restart` to zero its animation divider. Each channel is synchronised, debounced with a counter and edge-detected, with a fixed priority when presses coincide.

## Interface
- `DB_CYCLES`, default 1_000_000: stable-sample count required to accept a level change (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, default `$clog2(DB_CYCLES)`: debounce counter width.
- `clk`  in  1  system clock (100 MHz board clock).
- `clr_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `btn_l`  in  1  raw left button, asynchronous, active-high.
- `btn_r`  in  1  raw right button, asynchronous, active-high.
- `btn_c`  in  1  raw centre button, asynchronous, active-high.
- `press_l`, `press_r`, `press_c`  out  1 each  one-cycle pulse on an accepted press.
- `held`  out  3  debounced levels {c, r, l}.
- `rotation`  out  2  mode: 2'b00 left, 2'b01 right, 2'b10 centre; 2'b11 never driven.
- `restart`  out  1  one-cycle pulse, OR of the three press pulses.

## Operation
- Reset values: `press_*` = 0, `restart` = 0, `held` = 3'b000, `rotation` = 2'b10. Synchronisers and counters are 0.
- Per channel: a 2-FF synchroniser feeds `s`. Debounced state `d` (the `held` bit) and counter `cnt` follow these rules:
  - `s == d`: `cnt` <= 0.
  - `s != d` and `cnt == DB_CYCLES-1`: `d` <= `s` and `cnt` <= 0.
  - Otherwise `cnt` <= `cnt`+1.
- Any glitch back to `d` before terminal count clears `cnt`. A bounce shorter than `DB_CYCLES` samples never changes `d`.
- Press event: the 0→1 flip of `d` drives a registered `press_x` high for exactly one cycle. Release (1→0) produces no pulse.
- `rotation` loads on any press event, in the same cycle that the pulse is registered. Priority for coincident press events is C > R > L: C gives 10, else R gives 01, else L gives 00.
- All coincident `press_*` pulses still assert; priority affects only `rotation`.
- `restart` is registered with the pulses, so it is coincident with them.
- Holding a button produces one pulse only; there is no auto-repeat. A new pulse requires a debounced release followed by a debounced press.
- Mid-operation reset returns all state to the reset values. A button held through reset deassertion is seen as a new press: pulse after the normal latency, `rotation` updated.
- Counter never wraps: it saturates at terminal count by construction, because reaching it forces the clear.

## Timing
- Latency from the first `clk` edge that samples `btn_x` high to `press_x` high is `DB_CYCLES`+3 edges. This is 2 synchroniser edges, `DB_CYCLES` counting edges and 1 output-register edge.
- `held` rises one edge before `press_x`.
- Pulse width is exactly 1 cycle. The minimum spacing of two pulses on one channel is 2×`DB_CYCLES` cycles (debounced release then press).
- No handshake: consumers must sample `press_*` and `restart` every cycle. `rotation` is stable between press events.

## Structure
- Shared package `seg_pkg`: `rot_t` (2-bit enum ROT_L=2'b00, ROT_R=2'b01, ROT_C=2'b10) and `ROT_RESET = ROT_C`. The display block imports the same type.
- One sub-module, `debounce_channel` (params `DB_CYCLES`, `CNT_W`; ports `clk`, `clr_n`, `raw`, `level`, `rise`), instantiated three times.
- Top level contains only the priority encoder, the `rotation` register and the `restart` OR/register.

## Test plan
All directed tests use `DB_CYCLES`=4.
- Reset: assert `clr_n`=0 asynchronously mid-cycle. Required: all outputs take their reset values immediately, `rotation`=2'b10, `held`=000, no pulses.
- Clean press: hold `btn_l` high 20 cycles. Required: `press_l` is a single 1-cycle pulse 7 edges after the first sample, `restart` is coincident, `rotation`=00 from that cycle, and there is no pulse on release.
- Bounce: toggle `btn_r` with a 1,2,1,3-cycle high/low pattern, then hold. Required: no pulse during the bounce, and exactly one `press_r` 7 edges after the final rising sample, with `rotation`=01.
- Simultaneous: raise `btn_l`, `btn_r` and `btn_c` on the same cycle. Required: all three pulses in the same cycle, one `restart` pulse, `rotation`=10. Repeat with L+R only: `rotation`=01.
- Reset mid-debounce: raise `btn_c`, pulse `clr_n` low after 3 cycles, keep `btn_c` high. Required: no pulse before reset, and one `press_c` 7 edges after `clr_n` rises.
- Long hold: hold `btn_r` for 100 cycles. Required: exactly one `press_r`, and `held[1]`=1 throughout after acceptance.
